// File: rtl/skewed_data_feeder.sv
// Tile buffer and diagonal-skew streamer feeding one edge of a systolic MAC array.
// Channel c lags channel 0 by c cycles; lanes outside their window carry zero.
module skewed_data_feeder #(
   parameter int NUM_CH = 4,
   parameter int DEPTH  = 7,
   parameter int DATA_W = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            load_valid,
   output logic                            load_ready,
   input  logic [NUM_CH*DEPTH*DATA_W-1:0]  load_data,
   input  logic                            start,
   input  logic                            stall,
   output logic [NUM_CH*DATA_W-1:0]        data_out,
   output logic [NUM_CH-1:0]               out_valid,
   output logic                            busy,
   output logic                            done
);

   localparam int unsigned LEN    = DEPTH + NUM_CH - 1;
   localparam int unsigned CW     = $clog2(DEPTH + NUM_CH);
   localparam int unsigned TILE_W = NUM_CH * DEPTH * DATA_W;
   localparam logic [CW-1:0] LAST = CW'(LEN - 1);

   typedef enum logic [1:0] {IDLE, LOADED, STREAM} state_t;

   state_t                     state, state_n;
   logic [TILE_W-1:0]          tile_q, tile_n, src;
   logic [CW-1:0]              cnt, cnt_n, sel;
   logic                       emit;
   logic [NUM_CH*DATA_W-1:0]   data_n;
   logic [NUM_CH-1:0]          valid_n;
   logic                       done_n;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         tile_q    <= '0;
         cnt       <= '0;
         data_out  <= '0;
         out_valid <= '0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         tile_q    <= tile_n;
         cnt       <= cnt_n;
         data_out  <= data_n;
         out_valid <= valid_n;
         done      <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      tile_n  = tile_q;
      cnt_n   = cnt;
      data_n  = data_out;
      valid_n = out_valid;
      done_n  = 1'b0;
      src     = tile_q;
      sel     = '0;
      emit    = 1'b0;

      case (state)
         IDLE: begin
            data_n  = '0;
            valid_n = '0;
            if (load_valid) begin
               tile_n  = load_data;
               state_n = LOADED;
            end
         end
         LOADED: begin
            data_n  = '0;
            valid_n = '0;
            if (load_valid) tile_n = load_data;
            if (start) begin
               // first output word comes from the tile being captured this edge
               state_n = STREAM;
               cnt_n   = '0;
               src     = tile_n;
               sel     = '0;
               emit    = 1'b1;
            end
         end
         STREAM: begin
            if (!stall) begin
               if (cnt == LAST) begin
                  state_n = IDLE;
                  data_n  = '0;
                  valid_n = '0;
                  done_n  = 1'b1;
               end else begin
                  cnt_n = cnt + CW'(1);
                  sel   = cnt + CW'(1);
                  emit  = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      if (emit) begin
         data_n  = '0;
         valid_n = '0;
         // element k of channel c is due when the count equals c+k
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
               if (sel == CW'(c + k)) begin
                  data_n[c*DATA_W +: DATA_W] = src[c*DEPTH*DATA_W + (DEPTH-1-k)*DATA_W +: DATA_W];
                  valid_n[c] = 1'b1;
               end
            end
         end
      end
   end

   assign load_ready = (state == IDLE) || (state == LOADED);
   assign busy       = (state == STREAM);

endmodule

// File: tb/tb_skewed_data_feeder.sv
// Directed bench: a 2x3 instance for skew/stall/handshake/reset cases and a
// default 4x7 instance for a full-size tile.
module tb_skewed_data_feeder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        stall = 1'b0;

   logic        lv_s = 1'b0;
   logic        lr_s;
   logic [47:0] ld_s = '0;
   logic [15:0] do_s;
   logic [1:0]  ov_s;
   logic        busy_s, done_s;

   logic         lv_d = 1'b0;
   logic         lr_d;
   logic [223:0] ld_d = '0;
   logic [31:0]  do_d;
   logic [3:0]   ov_d;
   logic         busy_d, done_d;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]  el [4][7];
   logic [31:0] exp_d;
   logic [3:0]  exp_v;

   localparam logic [47:0] T1 = 48'h111213_010203;

   always #5 clk = ~clk;

   skewed_data_feeder #(.NUM_CH(2), .DEPTH(3), .DATA_W(8)) u_small (
      .clk(clk), .reset(reset), .load_valid(lv_s), .load_ready(lr_s),
      .load_data(ld_s), .start(start), .stall(stall), .data_out(do_s),
      .out_valid(ov_s), .busy(busy_s), .done(done_s)
   );

   skewed_data_feeder u_dflt (
      .clk(clk), .reset(reset), .load_valid(lv_d), .load_ready(lr_d),
      .load_data(ld_d), .start(start), .stall(stall), .data_out(do_d),
      .out_valid(ov_d), .busy(busy_d), .done(done_d)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_s(input string tag, input logic [15:0] d, input logic [1:0] v,
                        input logic dn, input logic bz, input logic lr);
      check({tag, ".data"},  64'(do_s),   64'(d));
      check({tag, ".valid"}, 64'(ov_s),   64'(v));
      check({tag, ".done"},  64'(done_s), 64'(dn));
      check({tag, ".busy"},  64'(busy_s), 64'(bz));
      check({tag, ".ready"}, 64'(lr_s),   64'(lr));
   endtask

   task automatic load_s(input logic [47:0] t);
      lv_s = 1'b1; ld_s = t;
      step();
      lv_s = 1'b0;
   endtask

   initial begin
      // reset
      step(); step();
      chk_s("reset", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b1);
      check("reset.d_ready", 64'(lr_d), 64'd1);
      reset = 1'b1;

      // start in IDLE is ignored
      start = 1'b1; step(); start = 1'b0;
      chk_s("idle_start", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b1);
      step();
      chk_s("idle_start2", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b1);

      // basic skew
      load_s(T1);
      chk_s("loaded", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b1);
      start = 1'b1; step(); start = 1'b0;
      chk_s("basic.c0", 16'h0001, 2'b01, 1'b0, 1'b1, 1'b0); step();
      chk_s("basic.c1", 16'h1102, 2'b11, 1'b0, 1'b1, 1'b0); step();
      chk_s("basic.c2", 16'h1203, 2'b11, 1'b0, 1'b1, 1'b0); step();
      chk_s("basic.c3", 16'h1300, 2'b10, 1'b0, 1'b1, 1'b0); step();
      chk_s("basic.done", 16'h0000, 2'b00, 1'b1, 1'b0, 1'b1); step();
      chk_s("basic.after", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b1);

      // stall at cnt=1 for two cycles, with a load attempt during STREAM
      load_s(T1);
      start = 1'b1; step(); start = 1'b0;
      chk_s("stall.c0", 16'h0001, 2'b01, 1'b0, 1'b1, 1'b0); step();
      chk_s("stall.c1", 16'h1102, 2'b11, 1'b0, 1'b1, 1'b0);
      stall = 1'b1; lv_s = 1'b1; ld_s = 48'hAAAAAA_555555;
      step();
      chk_s("stall.h1", 16'h1102, 2'b11, 1'b0, 1'b1, 1'b0);
      step();
      chk_s("stall.h2", 16'h1102, 2'b11, 1'b0, 1'b1, 1'b0);
      stall = 1'b0; lv_s = 1'b0;
      step();
      chk_s("stall.c2", 16'h1203, 2'b11, 1'b0, 1'b1, 1'b0); step();
      chk_s("stall.c3", 16'h1300, 2'b10, 1'b0, 1'b1, 1'b0); step();
      chk_s("stall.done", 16'h0000, 2'b00, 1'b1, 1'b0, 1'b1); step();
      chk_s("stall.after", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b1);

      // reload in LOADED with all-ones
      load_s(T1);
      load_s('1);
      start = 1'b1; step(); start = 1'b0;
      chk_s("ff.c0", 16'h00FF, 2'b01, 1'b0, 1'b1, 1'b0); step();
      chk_s("ff.c1", 16'hFFFF, 2'b11, 1'b0, 1'b1, 1'b0); step();
      chk_s("ff.c2", 16'hFFFF, 2'b11, 1'b0, 1'b1, 1'b0); step();
      chk_s("ff.c3", 16'hFF00, 2'b10, 1'b0, 1'b1, 1'b0); step();
      chk_s("ff.done", 16'h0000, 2'b00, 1'b1, 1'b0, 1'b1); step();

      // simultaneous load + start in LOADED
      load_s(T1);
      lv_s = 1'b1; ld_s = 48'h212223_7F8081; start = 1'b1;
      step();
      lv_s = 1'b0; start = 1'b0;
      chk_s("ls.c0", 16'h007F, 2'b01, 1'b0, 1'b1, 1'b0); step();
      chk_s("ls.c1", 16'h2180, 2'b11, 1'b0, 1'b1, 1'b0);
      check("ls.signed", 64'($signed(do_s[7:0]) == -8'sd128), 64'd1);
      step();
      chk_s("ls.c2", 16'h2281, 2'b11, 1'b0, 1'b1, 1'b0); step();
      chk_s("ls.c3", 16'h2300, 2'b10, 1'b0, 1'b1, 1'b0); step();
      chk_s("ls.done", 16'h0000, 2'b00, 1'b1, 1'b0, 1'b1); step();

      // reset mid-stream at cnt=2
      load_s(T1);
      start = 1'b1; step(); start = 1'b0;
      step(); step();
      chk_s("rst.c2", 16'h1203, 2'b11, 1'b0, 1'b1, 1'b0);
      reset = 1'b0; step(); reset = 1'b1;
      chk_s("rst.now", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b1);
      step();
      chk_s("rst.nodone", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b1);
      load_s(T1);
      start = 1'b1; step(); start = 1'b0;
      chk_s("rst2.c0", 16'h0001, 2'b01, 1'b0, 1'b1, 1'b0); step();
      chk_s("rst2.c1", 16'h1102, 2'b11, 1'b0, 1'b1, 1'b0); step();
      chk_s("rst2.c2", 16'h1203, 2'b11, 1'b0, 1'b1, 1'b0); step();
      chk_s("rst2.c3", 16'h1300, 2'b10, 1'b0, 1'b1, 1'b0); step();
      chk_s("rst2.done", 16'h0000, 2'b00, 1'b1, 1'b0, 1'b1); step();

      // default 4x7 tile; small instance is IDLE so the shared start is ignored there
      for (int c = 0; c < 4; c++)
         for (int k = 0; k < 7; k++) begin
            el[c][k] = 8'(c*55 + k*17 + 5);
            ld_d[c*56 + (6-k)*8 +: 8] = el[c][k];
         end
      lv_d = 1'b1; step(); lv_d = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      for (int t = 0; t < 10; t++) begin
         exp_d = '0;
         exp_v = '0;
         for (int c = 0; c < 4; c++) begin
            if (t - c >= 0 && t - c < 7) begin
               exp_d[c*8 +: 8] = el[c][t-c];
               exp_v[c] = 1'b1;
            end
         end
         check($sformatf("dflt.data%0d", t),  64'(do_d),   64'(exp_d));
         check($sformatf("dflt.valid%0d", t), 64'(ov_d),   64'(exp_v));
         check($sformatf("dflt.busy%0d", t),  64'(busy_d), 64'd1);
         check($sformatf("dflt.done%0d", t),  64'(done_d), 64'd0);
         step();
      end
      check("dflt.done",  64'(done_d), 64'd1);
      check("dflt.zero",  64'(do_d),   64'd0);
      check("dflt.busy",  64'(busy_d), 64'd0);
      check("dflt.small", 64'(busy_s), 64'd0);
      step();
      check("dflt.pulse", 64'(done_d), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/skewed_data_feeder.md
Name: skewed_data_feeder

Overview:
Multi-channel, parametrised successor to the single-lane 56-to-8 data feeder. Buffers one NUM_CH x DEPTH tile of signed DATA_W operands and streams it into one edge of the systolic MAC array, with channel c delayed by c cycles (diagonal skew) and zero padding outside each channel's valid window. It adds a ready/valid load handshake, start/stall/done sequencing and per-channel valid flags, which the single-lane shifter does not have.

Parameters:
NUM_CH, 4, number of output channels (array rows/columns fed)
DEPTH, 7, operands per channel per tile
DATA_W, 8, operand width in bits (signed)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising clk
load_valid  input  1  tile on load_data is valid
load_ready  output  1  feeder can accept a tile
load_data  input  NUM_CH*DEPTH*DATA_W  tile; channel c in bits [(c+1)*DEPTH*DATA_W-1 -: DEPTH*DATA_W], element k of a channel in [DEPTH*DATA_W-1-k*DATA_W -: DATA_W] (element 0 = MSB slice)
start  input  1  begin streaming the buffered tile
stall  input  1  freeze streaming (array back-pressure)
data_out  output  NUM_CH*DATA_W  signed operand, channel c in [c*DATA_W +: DATA_W]
out_valid  output  NUM_CH  per-channel operand valid
busy  output  1  high in STREAM
done  output  1  one-cycle pulse after the last streamed cycle

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE, tile buffer=0, cnt=0, data_out=0, out_valid=0, busy=0, done=0, load_ready=1 on the following cycle. Has priority over all other inputs, including mid-STREAM.
- States: IDLE, LOADED, STREAM. load_ready = (state==IDLE || state==LOADED), driven combinationally from state.
- IDLE: load_valid&&load_ready -> capture load_data, go LOADED. start ignored.
- LOADED: load_valid -> overwrite buffer, stay LOADED. start (with or without load_valid) -> go STREAM, cnt=0. If start and load_valid arrive together, the new tile is captured and streamed.
- STREAM: total length L = DEPTH+NUM_CH-1 output cycles, cnt = 0..L-1. Outputs are registered. In the first STREAM cycle, outputs show cnt=0. For each channel c: with j=cnt-c, if 0<=j<DEPTH then data_out[c]=element j and out_valid[c]=1, else data_out[c]=0 and out_valid[c]=0.
- Stall: stall=1 in STREAM holds cnt, data_out and out_valid unchanged. No element is skipped or duplicated beyond the hold.
- Completion: when cnt==L-1 and stall=0 at the clock edge -> state=IDLE, data_out=0, out_valid=0, done=1 for exactly one cycle, busy=0. Buffer contents are retained but considered consumed; a new load is required before the next start.
- load_valid and start during STREAM are ignored. load_ready=0 in STREAM.
- Width rules: cnt is $clog2(DEPTH+NUM_CH) bits. No arithmetic on data; operands pass through bit-exact.
- Degenerate cases: NUM_CH=1 gives an unskewed MSB-first stream of DEPTH cycles. DEPTH=1 is legal (L=NUM_CH).

Test Plan:
- Basic skew (NUM_CH=2, DEPTH=3, DATA_W=8): load ch0={01,02,03}, ch1={11,12,13}, then start -> ch0: 01,02,03,00 with valid 1,1,1,0; ch1: 00,11,12,13 with valid 0,1,1,1; done pulses on the 5th cycle after start, then load_ready=1.
- Stall mid-stream: same tile, stall=1 for 2 cycles at cnt=1 -> outputs hold {02,11} for 3 cycles total, then resume 03/12; done is delayed by exactly 2 cycles.
- Handshake: start in IDLE -> no busy, outputs stay 0. load_valid during STREAM -> load_ready=0 and buffer unchanged. Reload in LOADED with 0xFF.. -> stream shows FF values.
- Simultaneous load+start in LOADED with a new tile of ch0={7F,80,81} -> streams 7F,80,81 (80 output as signed -128, bit-exact).
- Reset mid-stream: reset=0 at cnt=2 -> next cycle data_out=0, out_valid=0, busy=0, no done pulse, state IDLE. A following load+start streams correctly.
- Default parameters (4x7): random tile -> each channel c emits its 7 elements MSB-first starting c cycles after start; total 10 cycles; data_out is zero whenever out_valid is 0.
